// File: rtl/wb_pkg.sv
// Shared types for the writeback/commit stage: FSM states and wb_exc bit layout.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_WAIT_MEM = 2'd2
    } wb_state_e;

    localparam int EXC_W = 12;

    // Bit positions inside wb_exc / ex_exc.
    localparam int EXC_INS_ACC_FAULT  = 0;
    localparam int EXC_INS_ADDR_MIS   = 1;
    localparam int EXC_INS_PAGE_FAULT = 2;
    localparam int EXC_LD_ADDR_MIS    = 3;
    localparam int EXC_ST_ADDR_MIS    = 4;
    localparam int EXC_LD_ACC_FAULT   = 5;
    localparam int EXC_ST_ACC_FAULT   = 6;
    localparam int EXC_LD_PAGE_FAULT  = 7;
    localparam int EXC_ST_PAGE_FAULT  = 8;
    localparam int EXC_ILL_INS        = 9;
    localparam int EXC_ECALL          = 10;
    localparam int EXC_EBREAK         = 11;

    // Flag vector raised when a load response comes back with an access error.
    localparam logic [EXC_W-1:0] LD_ACC_FAULT_FLAG = EXC_W'(1) << EXC_LD_ACC_FAULT;

endpackage

// File: rtl/wb_retire_cnt.sv
// Retired-instruction counter; wraps from all-ones back to zero.
module wb_retire_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per clean retirement; synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: accepts one EX result per cycle, waits for load data
// when needed and presents a registered commit record to cu_ru.
module wb_commit
    import wb_pkg::*;
#(
    parameter int DDATA_W = 64,
    parameter int VDATA_W = 128,
    parameter int IADDR_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [63:0]        ex_pc,
    input  logic [4:0]         ex_rd,
    input  logic [4:0]         ex_fd,
    input  logic [4:0]         ex_vd,
    input  logic [11:0]        ex_csr_index,
    input  logic               ex_gpr_w,
    input  logic               ex_fgpr_w,
    input  logic               ex_vgpr_w,
    input  logic               ex_csr_w,
    input  logic               ex_jmp,
    input  logic [DDATA_W-1:0] ex_data,
    input  logic [VDATA_W-1:0] ex_vdata,
    input  logic [DDATA_W-1:0] ex_csr_data,
    input  logic [IADDR_W-1:0] ex_new_pc,
    input  logic               ex_is_load,
    input  logic [EXC_W-1:0]   ex_exc,
    input  logic [63:0]        ex_exc_code,
    input  logic               mem_rsp_valid,
    input  logic [DDATA_W-1:0] mem_rsp_data,
    input  logic               mem_rsp_err,
    input  logic               pip_flush,
    input  logic               int_req,
    output logic               valid,
    output logic               gpr_write,
    output logic               fgpr_write,
    output logic               vgpr_write,
    output logic               csr_write,
    output logic               pc_jmp,
    output logic [4:0]         rd_index,
    output logic [4:0]         fd_index,
    output logic [4:0]         vd_index,
    output logic [11:0]        csr_index,
    output logic [DDATA_W-1:0] data_rd,
    output logic [DDATA_W-1:0] data_fd,
    output logic [DDATA_W-1:0] data_csr,
    output logic [VDATA_W-1:0] data_vd,
    output logic [IADDR_W-1:0] new_pc,
    output logic [63:0]        ins_pc,
    output logic [63:0]        exc_code,
    output logic [EXC_W-1:0]   wb_exc,
    output logic               int_acc,
    output logic [63:0]        instret
);

    // Load entry parked while the memory response is outstanding.
    typedef struct packed {
        logic [63:0]        pc;
        logic [4:0]         rd;
        logic [4:0]         fd;
        logic [4:0]         vd;
        logic [11:0]        csr_index;
        logic               gpr_w;
        logic               fgpr_w;
        logic               vgpr_w;
        logic               csr_w;
        logic               jmp;
        logic [VDATA_W-1:0] vdata;
        logic [DDATA_W-1:0] csr_data;
        logic [IADDR_W-1:0] new_pc;
        logic [63:0]        exc_code;
    } pend_t;

    // Everything cu_ru sees on a commit.
    typedef struct packed {
        logic               gpr_write;
        logic               fgpr_write;
        logic               vgpr_write;
        logic               csr_write;
        logic               pc_jmp;
        logic [4:0]         rd_index;
        logic [4:0]         fd_index;
        logic [4:0]         vd_index;
        logic [11:0]        csr_index;
        logic [DDATA_W-1:0] data_rd;
        logic [DDATA_W-1:0] data_fd;
        logic [DDATA_W-1:0] data_csr;
        logic [VDATA_W-1:0] data_vd;
        logic [IADDR_W-1:0] new_pc;
        logic [63:0]        ins_pc;
        logic [63:0]        exc_code;
        logic [EXC_W-1:0]   wb_exc;
    } commit_t;

    wb_state_e state;
    wb_state_e state_next;
    logic      accept;
    logic      take_ex;
    logic      take_mem;
    logic      hold_load;
    pend_t     pend;
    commit_t   cur;
    commit_t   nxt;

    assign ex_ready = (state != ST_WAIT_MEM);
    assign accept   = ex_valid && ex_ready && !pip_flush;
    assign valid    = (state == ST_COMMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the three load strobes for the datapath.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_next = state;
        take_ex    = 1'b0;
        take_mem   = 1'b0;
        hold_load  = 1'b0;
        unique case (state)
            ST_IDLE, ST_COMMIT: begin
                if (accept) begin
                    if (ex_is_load && !(|ex_exc)) begin
                        state_next = ST_WAIT_MEM;
                        hold_load  = 1'b1;
                    end else begin
                        state_next = ST_COMMIT;
                        take_ex    = 1'b1;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                // A flush kills the parked load; its late response is then ignored.
                if (pip_flush) begin
                    state_next = ST_IDLE;
                end else if (mem_rsp_valid) begin
                    state_next = ST_COMMIT;
                    take_mem   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Park the load entry; only read back after hold_load has written it.
    always_ff @(posedge clk) begin
        // NOTE: no reset here -- contents are never observed before being written.
        if (hold_load) begin
            pend <= '{pc: ex_pc, rd: ex_rd, fd: ex_fd, vd: ex_vd,
                      csr_index: ex_csr_index, gpr_w: ex_gpr_w,
                      fgpr_w: ex_fgpr_w, vgpr_w: ex_vgpr_w, csr_w: ex_csr_w,
                      jmp: ex_jmp, vdata: ex_vdata, csr_data: ex_csr_data,
                      new_pc: ex_new_pc, exc_code: ex_exc_code};
        end
    end

    // Build the next commit record from either EX or the parked load, then mask writes on exception.
    always_comb begin
        nxt = '0;
        if (take_mem) begin
            nxt.gpr_write  = pend.gpr_w;
            nxt.fgpr_write = pend.fgpr_w;
            nxt.vgpr_write = pend.vgpr_w;
            nxt.csr_write  = pend.csr_w;
            nxt.pc_jmp     = pend.jmp;
            nxt.rd_index   = pend.rd;
            nxt.fd_index   = pend.fd;
            nxt.vd_index   = pend.vd;
            nxt.csr_index  = pend.csr_index;
            nxt.data_rd    = mem_rsp_data;
            nxt.data_fd    = mem_rsp_data;
            nxt.data_csr   = pend.csr_data;
            nxt.data_vd    = pend.vdata;
            nxt.new_pc     = pend.new_pc;
            nxt.ins_pc     = pend.pc;
            nxt.exc_code   = mem_rsp_err ? pend.pc : pend.exc_code;
            nxt.wb_exc     = mem_rsp_err ? LD_ACC_FAULT_FLAG : '0;
        end else begin
            nxt.gpr_write  = ex_gpr_w;
            nxt.fgpr_write = ex_fgpr_w;
            nxt.vgpr_write = ex_vgpr_w;
            nxt.csr_write  = ex_csr_w;
            nxt.pc_jmp     = ex_jmp;
            nxt.rd_index   = ex_rd;
            nxt.fd_index   = ex_fd;
            nxt.vd_index   = ex_vd;
            nxt.csr_index  = ex_csr_index;
            nxt.data_rd    = ex_data;
            nxt.data_fd    = ex_data;
            nxt.data_csr   = ex_csr_data;
            nxt.data_vd    = ex_vdata;
            nxt.new_pc     = ex_new_pc;
            nxt.ins_pc     = ex_pc;
            nxt.exc_code   = ex_exc_code;
            nxt.wb_exc     = ex_exc;
        end
        if (|nxt.wb_exc) begin
            nxt.gpr_write  = 1'b0;
            nxt.fgpr_write = 1'b0;
            nxt.vgpr_write = 1'b0;
            nxt.csr_write  = 1'b0;
            nxt.pc_jmp     = 1'b0;
        end
    end

    // Commit record register: loaded only on a new commit, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else if (take_ex || take_mem) begin
            cur <= nxt;
        end
    end

    assign gpr_write  = cur.gpr_write;
    assign fgpr_write = cur.fgpr_write;
    assign vgpr_write = cur.vgpr_write;
    assign csr_write  = cur.csr_write;
    assign pc_jmp     = cur.pc_jmp;
    assign rd_index   = cur.rd_index;
    assign fd_index   = cur.fd_index;
    assign vd_index   = cur.vd_index;
    assign csr_index  = cur.csr_index;
    assign data_rd    = cur.data_rd;
    assign data_fd    = cur.data_fd;
    assign data_csr   = cur.data_csr;
    assign data_vd    = cur.data_vd;
    assign new_pc     = cur.new_pc;
    assign ins_pc     = cur.ins_pc;
    assign exc_code   = cur.exc_code;
    assign wb_exc     = cur.wb_exc;

    assign int_acc = valid && int_req && !(|cur.wb_exc);

    wb_retire_cnt #(
        .CNT_W (64)
    ) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid && !(|cur.wb_exc)),
        .count (instret)
    );

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed vector table plus randomized
// traffic compared against a transaction-level model.
module tb_wb_commit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ex_valid, ex_ready;
    logic [63:0]   ex_pc;
    logic [4:0]    ex_rd, ex_fd, ex_vd;
    logic [11:0]   ex_csr_index;
    logic          ex_gpr_w, ex_fgpr_w, ex_vgpr_w, ex_csr_w, ex_jmp;
    logic [63:0]   ex_data, ex_csr_data, ex_new_pc, ex_exc_code;
    logic [127:0]  ex_vdata;
    logic          ex_is_load;
    logic [11:0]   ex_exc;
    logic          mem_rsp_valid, mem_rsp_err;
    logic [63:0]   mem_rsp_data;
    logic          pip_flush, int_req;
    logic          valid, gpr_write, fgpr_write, vgpr_write, csr_write, pc_jmp;
    logic [4:0]    rd_index, fd_index, vd_index;
    logic [11:0]   csr_index;
    logic [63:0]   data_rd, data_fd, data_csr, new_pc, ins_pc, exc_code, instret;
    logic [127:0]  data_vd;
    logic [11:0]   wb_exc;
    logic          int_acc;

    wb_commit #(.DDATA_W(64), .VDATA_W(128), .IADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_fd(ex_fd), .ex_vd(ex_vd), .ex_csr_index(ex_csr_index),
        .ex_gpr_w(ex_gpr_w), .ex_fgpr_w(ex_fgpr_w), .ex_vgpr_w(ex_vgpr_w),
        .ex_csr_w(ex_csr_w), .ex_jmp(ex_jmp),
        .ex_data(ex_data), .ex_vdata(ex_vdata), .ex_csr_data(ex_csr_data),
        .ex_new_pc(ex_new_pc), .ex_is_load(ex_is_load), .ex_exc(ex_exc),
        .ex_exc_code(ex_exc_code),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .pip_flush(pip_flush), .int_req(int_req),
        .valid(valid), .gpr_write(gpr_write), .fgpr_write(fgpr_write),
        .vgpr_write(vgpr_write), .csr_write(csr_write), .pc_jmp(pc_jmp),
        .rd_index(rd_index), .fd_index(fd_index), .vd_index(vd_index),
        .csr_index(csr_index), .data_rd(data_rd), .data_fd(data_fd),
        .data_csr(data_csr), .data_vd(data_vd), .new_pc(new_pc),
        .ins_pc(ins_pc), .exc_code(exc_code), .wb_exc(wb_exc),
        .int_acc(int_acc), .instret(instret)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic         valid, gpr_w, fgpr_w, vgpr_w, csr_w, jmp;
        logic [4:0]   rd, fd, vd;
        logic [11:0]  csr_index;
        logic [63:0]  data_rd, data_fd, data_csr, new_pc, ins_pc, exc_code;
        logic [127:0] data_vd;
        logic [11:0]  exc;
    } rec_t;

    rec_t        m_out;    // record visible on the commit outputs
    rec_t        m_pend;   // load waiting for its data
    logic        m_wait;
    logic [63:0] m_cnt;

    function automatic rec_t from_ex();
        rec_t r;
        r.valid = 1'b1;
        r.gpr_w = ex_gpr_w; r.fgpr_w = ex_fgpr_w; r.vgpr_w = ex_vgpr_w;
        r.csr_w = ex_csr_w; r.jmp = ex_jmp;
        r.rd = ex_rd; r.fd = ex_fd; r.vd = ex_vd; r.csr_index = ex_csr_index;
        r.data_rd = ex_data; r.data_fd = ex_data; r.data_csr = ex_csr_data;
        r.data_vd = ex_vdata; r.new_pc = ex_new_pc; r.ins_pc = ex_pc;
        r.exc_code = ex_exc_code; r.exc = ex_exc;
        return r;
    endfunction

    function automatic rec_t masked(input rec_t r);
        rec_t o = r;
        if (r.exc != 12'h000) begin
            o.gpr_w = 0; o.fgpr_w = 0; o.vgpr_w = 0; o.csr_w = 0; o.jmp = 0;
        end
        return o;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        rec_t r;
        if (rst) begin
            m_out = '{default: 0};
            m_wait = 1'b0;
            m_cnt = 64'd0;
            return;
        end
        if (m_out.valid && m_out.exc == 12'h000) m_cnt = m_cnt + 64'd1;
        m_out.valid = 1'b0;
        if (m_wait) begin
            if (pip_flush) begin
                m_wait = 1'b0;
            end else if (mem_rsp_valid) begin
                r = m_pend;
                r.data_rd = mem_rsp_data;
                r.data_fd = mem_rsp_data;
                if (mem_rsp_err) begin
                    r.exc = 12'h020;
                    r.exc_code = r.ins_pc;
                end
                m_out = masked(r);
                m_wait = 1'b0;
            end
        end else if (ex_valid && !pip_flush) begin
            r = from_ex();
            if (ex_is_load && ex_exc == 12'h000) begin
                m_pend = r;
                m_wait = 1'b1;
            end else begin
                m_out = masked(r);
            end
        end
    endtask

    task automatic check_model();
        check("ex_ready",   ex_ready,   !m_wait);
        check("valid",      valid,      m_out.valid);
        check("gpr_write",  gpr_write,  m_out.gpr_w);
        check("fgpr_write", fgpr_write, m_out.fgpr_w);
        check("vgpr_write", vgpr_write, m_out.vgpr_w);
        check("csr_write",  csr_write,  m_out.csr_w);
        check("pc_jmp",     pc_jmp,     m_out.jmp);
        check("rd_index",   rd_index,   m_out.rd);
        check("fd_index",   fd_index,   m_out.fd);
        check("vd_index",   vd_index,   m_out.vd);
        check("csr_index",  csr_index,  m_out.csr_index);
        check("data_rd",    data_rd,    m_out.data_rd);
        check("data_fd",    data_fd,    m_out.data_fd);
        check("data_csr",   data_csr,   m_out.data_csr);
        check("data_vd",    data_vd,    m_out.data_vd);
        check("new_pc",     new_pc,     m_out.new_pc);
        check("ins_pc",     ins_pc,     m_out.ins_pc);
        check("exc_code",   exc_code,   m_out.exc_code);
        check("wb_exc",     wb_exc,     m_out.exc);
        check("int_acc",    int_acc,    m_out.valid && int_req && m_out.exc == 12'h000);
        check("instret",    instret,    m_cnt);
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_pc = '0; ex_rd = '0; ex_fd = '0; ex_vd = '0; ex_csr_index = '0;
        ex_gpr_w = 0; ex_fgpr_w = 0; ex_vgpr_w = 0; ex_csr_w = 0; ex_jmp = 0;
        ex_data = '0; ex_vdata = '0; ex_csr_data = '0; ex_new_pc = '0; ex_is_load = 0;
        ex_exc = '0; ex_exc_code = '0; mem_rsp_valid = 0; mem_rsp_data = '0;
        mem_rsp_err = 0; pip_flush = 0; int_req = 0;
    endtask

    // ---------------- directed vector table ----------------
    // Expected fields describe the outputs visible during the row's cycle,
    // before the edge that consumes the row's inputs.
    typedef struct {
        logic rst, ev, ld, gw, jmp;
        logic [4:0] rd;
        logic [63:0] pc, data;
        logic [11:0] exc;
        logic mv;
        logic [63:0] md;
        logic merr, fl, ir;
        logic e_ready, e_valid, e_gpr, e_jmp;
        logic [4:0] e_rd;
        logic [63:0] e_data;
        logic [11:0] e_exc;
        logic [63:0] e_code;
        logic e_int;
        logic [63:0] e_inst;
    } vec_t;

    function automatic vec_t row(
        input logic r, ev, ld, gw, jmp, input logic [4:0] rd, input logic [63:0] pc, data,
        input logic [11:0] exc, input logic mv, input logic [63:0] md, input logic merr, fl, ir,
        input logic e_ready, e_valid, e_gpr, e_jmp, input logic [4:0] e_rd,
        input logic [63:0] e_data, input logic [11:0] e_exc, input logic [63:0] e_code,
        input logic e_int, input logic [63:0] e_inst);
        vec_t v;
        v.rst = r; v.ev = ev; v.ld = ld; v.gw = gw; v.jmp = jmp; v.rd = rd; v.pc = pc;
        v.data = data; v.exc = exc; v.mv = mv; v.md = md; v.merr = merr; v.fl = fl; v.ir = ir;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_gpr = e_gpr; v.e_jmp = e_jmp;
        v.e_rd = e_rd; v.e_data = e_data; v.e_exc = e_exc; v.e_code = e_code;
        v.e_int = e_int; v.e_inst = e_inst;
        return v;
    endfunction

    vec_t vt[23];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst ev ld gw jp rd  pc      data     exc     mv md       me fl ir | rdy val gpr jmp rd dat      exc     code   int inst
        vt[0]  = row(0, 1, 0, 1, 0, 5,  'h100, 'h11,    12'h000, 0, 0,       0, 0, 0,   1, 0, 0, 0, 0,  0,       12'h000, 0,     0, 0);
        vt[1]  = row(0, 1, 0, 1, 0, 6,  'h104, 'h22,    12'h000, 0, 0,       0, 0, 0,   1, 1, 1, 0, 5,  'h11,    12'h000, 0,     0, 0);
        vt[2]  = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 1,   1, 1, 1, 0, 6,  'h22,    12'h000, 0,     1, 1);
        vt[3]  = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 1, 0, 6,  'h22,    12'h000, 0,     0, 2);
        vt[4]  = row(0, 1, 1, 1, 0, 7,  'h200, 0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 1, 0, 6,  'h22,    12'h000, 0,     0, 2);
        vt[5]  = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   0, 0, 1, 0, 6,  'h22,    12'h000, 0,     0, 2);
        vt[6]  = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   0, 0, 1, 0, 6,  'h22,    12'h000, 0,     0, 2);
        vt[7]  = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 1, 'hDEAD,  0, 0, 0,   0, 0, 1, 0, 6,  'h22,    12'h000, 0,     0, 2);
        vt[8]  = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   1, 1, 1, 0, 7,  'hDEAD,  12'h000, 0,     0, 2);
        vt[9]  = row(0, 1, 1, 1, 0, 8,  'h80,  0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 1, 0, 7,  'hDEAD,  12'h000, 0,     0, 3);
        vt[10] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 1, 'hDEAD,  1, 0, 0,   0, 0, 1, 0, 7,  'hDEAD,  12'h000, 0,     0, 3);
        vt[11] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 1,   1, 1, 0, 0, 8,  'hDEAD,  12'h020, 'h80,  0, 3);
        vt[12] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 0, 0, 8,  'hDEAD,  12'h020, 'h80,  0, 3);
        vt[13] = row(0, 1, 0, 1, 1, 9,  'h300, 'h33,    12'h200, 0, 0,       0, 0, 0,   1, 0, 0, 0, 8,  'hDEAD,  12'h020, 'h80,  0, 3);
        vt[14] = row(0, 1, 0, 1, 0, 10, 'h304, 'h44,    12'h000, 0, 0,       0, 1, 0,   1, 1, 0, 0, 9,  'h33,    12'h200, 0,     0, 3);
        vt[15] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 0, 0, 9,  'h33,    12'h200, 0,     0, 3);
        vt[16] = row(0, 1, 0, 1, 0, 11, 'h400, 'h66,    12'h400, 0, 0,       0, 0, 0,   1, 0, 0, 0, 9,  'h33,    12'h200, 0,     0, 3);
        vt[17] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 1,   1, 1, 0, 0, 11, 'h66,    12'h400, 0,     0, 3);
        vt[18] = row(0, 1, 1, 1, 0, 12, 'h500, 0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 0, 0, 11, 'h66,    12'h400, 0,     0, 3);
        vt[19] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   0, 0, 0, 0, 11, 'h66,    12'h400, 0,     0, 3);
        vt[20] = row(1, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   0, 0, 0, 0, 11, 'h66,    12'h400, 0,     0, 3);
        vt[21] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 1, 'hBEEF,  0, 0, 0,   1, 0, 0, 0, 0,  0,       12'h000, 0,     0, 0);
        vt[22] = row(0, 0, 0, 0, 0, 0,  0,     0,       12'h000, 0, 0,       0, 0, 0,   1, 0, 0, 0, 0,  0,       12'h000, 0,     0, 0);

        // Reset: two edges with rst high, then check the cleared state.
        clear_inputs();
        rst = 1'b1;
        m_out = '{default: 0}; m_pend = '{default: 0}; m_wait = 1'b0; m_cnt = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset valid",   valid,    1'b0);
        check("reset ready",   ex_ready, 1'b1);
        check("reset gpr_w",   gpr_write, 1'b0);
        check("reset data_rd", data_rd,  64'd0);
        check("reset instret", instret,  64'd0);
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            clear_inputs();
            rst = vt[i].rst; ex_valid = vt[i].ev; ex_is_load = vt[i].ld;
            ex_gpr_w = vt[i].gw; ex_jmp = vt[i].jmp; ex_rd = vt[i].rd; ex_pc = vt[i].pc;
            ex_data = vt[i].data; ex_exc = vt[i].exc; mem_rsp_valid = vt[i].mv;
            mem_rsp_data = vt[i].md; mem_rsp_err = vt[i].merr; pip_flush = vt[i].fl;
            int_req = vt[i].ir;
            #1;
            check($sformatf("vec%0d ex_ready", i),  ex_ready,  vt[i].e_ready);
            check($sformatf("vec%0d valid", i),     valid,     vt[i].e_valid);
            check($sformatf("vec%0d gpr_write", i), gpr_write, vt[i].e_gpr);
            check($sformatf("vec%0d pc_jmp", i),    pc_jmp,    vt[i].e_jmp);
            check($sformatf("vec%0d rd_index", i),  rd_index,  vt[i].e_rd);
            check($sformatf("vec%0d data_rd", i),   data_rd,   vt[i].e_data);
            check($sformatf("vec%0d wb_exc", i),    wb_exc,    vt[i].e_exc);
            check($sformatf("vec%0d exc_code", i),  exc_code,  vt[i].e_code);
            check($sformatf("vec%0d int_acc", i),   int_acc,   vt[i].e_int);
            check($sformatf("vec%0d instret", i),   instret,   vt[i].e_inst);
            check_model();
            model_step();
            @(negedge clk);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [11:0] one;
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            ex_valid = ($urandom_range(0, 9) < 6);
            ex_is_load = ($urandom_range(0, 9) < 4);
            one = 12'h001 << $urandom_range(0, 11);
            ex_exc = ($urandom_range(0, 6) == 0) ? one : 12'h000;
            ex_pc = {$urandom, $urandom};
            ex_rd = 5'($urandom); ex_fd = 5'($urandom); ex_vd = 5'($urandom);
            ex_csr_index = 12'($urandom);
            ex_gpr_w = 1'($urandom); ex_fgpr_w = 1'($urandom); ex_vgpr_w = 1'($urandom);
            ex_csr_w = 1'($urandom); ex_jmp = 1'($urandom);
            ex_data = {$urandom, $urandom}; ex_csr_data = {$urandom, $urandom};
            ex_vdata = {$urandom, $urandom, $urandom, $urandom};
            ex_new_pc = {$urandom, $urandom}; ex_exc_code = {$urandom, $urandom};
            mem_rsp_valid = ($urandom_range(0, 99) < 35);
            mem_rsp_data = {$urandom, $urandom};
            mem_rsp_err = ($urandom_range(0, 3) == 0);
            pip_flush = ($urandom_range(0, 14) == 0);
            int_req = 1'($urandom);
            #1;
            check_model();
            model_step();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
